l2_arbiter: RTL and testbench

- Shares the single L2/physical-memory line port between the L1 I-cache miss path and the L1 D-cache miss/writeback path of the pipelined LC-3b core.
- Sits below both L1 caches and above the L2 cache.
- Serves one outstanding transaction at a time.
- D-cache has priority; a bounded-streak guard prevents I-cache starvation.

---
 rtl/l2_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_l2_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_arbiter.sv
// ----------------------------------------------------------------------------
// l2_arbiter
//
// Purpose:
//   Shares the single L2 line port between the L1 I-cache miss path and the
//   L1 D-cache miss/writeback path. One transaction is outstanding at a time.
//   The D-cache wins arbitration, except that after MAX_D_STREAK consecutive
//   D grants issued while an I request was waiting, the I-cache is served.
//
// Optional feature:
//   L2_ARB_PERF_EN - when defined, perf_i_grants / perf_d_grants /
//   perf_i_wait are 16-bit saturating event counters cleared by reset.
//   When undefined the perf_* ports are tied to zero and no counter flops
//   exist.
//
// Ports:
//   clk            system clock, all state on the rising edge
//   reset          synchronous, active-high
//   i_read         I-cache line read request (level, held until i_resp)
//   i_addr         I-cache line address
//   i_rdata        read line to the I-cache (always l2_rdata)
//   i_resp         one-cycle completion pulse to the I-cache
//   d_read         D-cache line read request (level)
//   d_write        D-cache writeback request (level)
//   d_addr         D-cache line address
//   d_wdata        D-cache writeback line
//   d_rdata        read line to the D-cache (always l2_rdata)
//   d_resp         one-cycle completion pulse to the D-cache
//   l2_read        read request to L2 (level)
//   l2_write       write request to L2 (level)
//   l2_addr        address to L2
//   l2_wdata       write data to L2
//   l2_rdata       L2 read data, valid with l2_resp
//   l2_resp        L2 completion pulse
//   perf_i_grants  I grant count
//   perf_d_grants  D grant count
//   perf_i_wait    cycles with i_read high while not in SERVE_I
// ----------------------------------------------------------------------------
module l2_arbiter #(
   parameter int ADDR_W       = 16,
   parameter int LINE_W       = 128,
   parameter int MAX_D_STREAK = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              l2_read,
   output logic              l2_write,
   output logic [ADDR_W-1:0] l2_addr,
   output logic [LINE_W-1:0] l2_wdata,
   input  logic [LINE_W-1:0] l2_rdata,
   input  logic              l2_resp,
   output logic [15:0]       perf_i_grants,
   output logic [15:0]       perf_d_grants,
   output logic [15:0]       perf_i_wait
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SERVE_I = 2'd1,
      ST_SERVE_D = 2'd2
   } state_e;

   // Streak limit as a 4-bit value (legal range 1..15 fits exactly).
   localparam logic [3:0] MAX_STREAK = 4'(MAX_D_STREAK);

   state_e     state_q;
   state_e     state_d;
   logic [3:0] streak_q;
   logic [3:0] streak_d;
   logic       d_req_s;
   logic       i_starved_s;

   assign d_req_s     = d_read | d_write;
   // I has watched the limit of D grants go by; it must win this decision.
   assign i_starved_s = i_read & (streak_q == MAX_STREAK);

   // State and streak registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         streak_q <= 4'd0;
      end else begin
         state_q  <= state_d;
         streak_q <= streak_d;
      end
   end

   // Arbitration decision in IDLE and completion tracking in SERVE_x.
   always_comb begin
      state_d  = state_q;
      streak_d = streak_q;
      case (state_q)
         ST_IDLE: begin
            if (d_req_s && !i_starved_s) begin
               state_d = ST_SERVE_D;
               // The streak only grows while an I request is being passed over.
               if (i_read) begin
                  if (streak_q != MAX_STREAK) begin
                     streak_d = streak_q + 4'd1;
                  end else begin
                     streak_d = streak_q;
                  end
               end else begin
                  streak_d = 4'd0;
               end
            end else if (i_read) begin
               state_d  = ST_SERVE_I;
               streak_d = 4'd0;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_SERVE_I: begin
            // Always return to IDLE after completion so the requester
            // gets a cycle to drop its level request.
            if (l2_resp) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_SERVE_I;
            end
         end
         ST_SERVE_D: begin
            if (l2_resp) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_SERVE_D;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            streak_d = 4'd0;
         end
      endcase
   end

   // L2 port and response steering from the registered state.
   always_comb begin
      l2_read  = 1'b0;
      l2_write = 1'b0;
      l2_addr  = {ADDR_W{1'b0}};
      l2_wdata = {LINE_W{1'b0}};
      i_resp   = 1'b0;
      d_resp   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // l2_resp is deliberately ignored here.
            l2_read  = 1'b0;
            l2_write = 1'b0;
         end
         ST_SERVE_I: begin
            l2_read = 1'b1;
            l2_addr = i_addr;
            i_resp  = l2_resp;
         end
         ST_SERVE_D: begin
            // A writeback takes precedence if both requests are raised.
            l2_write = d_write;
            l2_read  = d_read & ~d_write;
            l2_addr  = d_addr;
            l2_wdata = d_wdata;
            d_resp   = l2_resp;
         end
         default: begin
            l2_read  = 1'b0;
            l2_write = 1'b0;
         end
      endcase
   end

   // Read data fans out unconditionally; only the resp pulses are steered.
   assign i_rdata = l2_rdata;
   assign d_rdata = l2_rdata;

`ifdef L2_ARB_PERF_EN
   logic [15:0] perf_i_grants_q;
   logic [15:0] perf_d_grants_q;
   logic [15:0] perf_i_wait_q;
   logic        grant_i_s;
   logic        grant_d_s;
   logic        i_waiting_s;

   assign grant_i_s   = (state_q == ST_IDLE) & (state_d == ST_SERVE_I);
   assign grant_d_s   = (state_q == ST_IDLE) & (state_d == ST_SERVE_D);
   assign i_waiting_s = i_read & (state_q != ST_SERVE_I);

   // Saturating event counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_i_grants_q <= 16'd0;
         perf_d_grants_q <= 16'd0;
         perf_i_wait_q   <= 16'd0;
      end else begin
         if (grant_i_s && (perf_i_grants_q != 16'hFFFF)) begin
            perf_i_grants_q <= perf_i_grants_q + 16'd1;
         end
         if (grant_d_s && (perf_d_grants_q != 16'hFFFF)) begin
            perf_d_grants_q <= perf_d_grants_q + 16'd1;
         end
         if (i_waiting_s && (perf_i_wait_q != 16'hFFFF)) begin
            perf_i_wait_q <= perf_i_wait_q + 16'd1;
         end
      end
   end

   assign perf_i_grants = perf_i_grants_q;
   assign perf_d_grants = perf_d_grants_q;
   assign perf_i_wait   = perf_i_wait_q;
`else
   assign perf_i_grants = 16'd0;
   assign perf_d_grants = 16'd0;
   assign perf_i_wait   = 16'd0;
`endif

endmodule

// File: tb/tb_l2_arbiter.sv
// ----------------------------------------------------------------------------
// tb_l2_arbiter
//
// Self-checking bench for l2_arbiter. A transaction-level reference model
// (who is being served, the pass-over streak, event tallies) predicts every
// output each cycle; directed sequences cover the named scenarios and a
// randomized phase exercises arbitrary request / response interleavings.
// Honors L2_ARB_PERF_EN for the perf counter expectations.
// ----------------------------------------------------------------------------
module tb_l2_arbiter;

   localparam int ADDR_W = 16;
   localparam int LINE_W = 128;
   localparam int MAXS   = 4;

   logic              clk;
   logic              reset;
   logic              i_read;
   logic [ADDR_W-1:0] i_addr;
   logic [LINE_W-1:0] i_rdata;
   logic              i_resp;
   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_addr;
   logic [LINE_W-1:0] d_wdata;
   logic [LINE_W-1:0] d_rdata;
   logic              d_resp;
   logic              l2_read;
   logic              l2_write;
   logic [ADDR_W-1:0] l2_addr;
   logic [LINE_W-1:0] l2_wdata;
   logic [LINE_W-1:0] l2_rdata;
   logic              l2_resp;
   logic [15:0]       perf_i_grants;
   logic [15:0]       perf_d_grants;
   logic [15:0]       perf_i_wait;

   int total;
   int bad;

   // Reference model: who owns the port (0 none, 1 I-cache, 2 D-cache),
   // how many D grants in a row have passed over a waiting I request,
   // and event tallies.
   int m_owner;
   int m_streak;
   int m_ig;
   int m_dg;
   int m_iw;
   logic e_i_resp;
   logic e_d_resp;

   l2_arbiter #(
      .ADDR_W       (ADDR_W),
      .LINE_W       (LINE_W),
      .MAX_D_STREAK (MAXS)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .i_read        (i_read),
      .i_addr        (i_addr),
      .i_rdata       (i_rdata),
      .i_resp        (i_resp),
      .d_read        (d_read),
      .d_write       (d_write),
      .d_addr        (d_addr),
      .d_wdata       (d_wdata),
      .d_rdata       (d_rdata),
      .d_resp        (d_resp),
      .l2_read       (l2_read),
      .l2_write      (l2_write),
      .l2_addr       (l2_addr),
      .l2_wdata      (l2_wdata),
      .l2_rdata      (l2_rdata),
      .l2_resp       (l2_resp),
      .perf_i_grants (perf_i_grants),
      .perf_d_grants (perf_d_grants),
      .perf_i_wait   (perf_i_wait)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Sample on the falling edge and compare every output with the model.
   task automatic samp();
      logic              x_rd;
      logic              x_wr;
      logic [ADDR_W-1:0] x_addr;
      logic [LINE_W-1:0] x_wdata;
      logic [15:0]       x_ig;
      logic [15:0]       x_dg;
      logic [15:0]       x_iw;
      @(negedge clk);
      x_rd = 1'b0; x_wr = 1'b0; x_addr = '0; x_wdata = '0;
      e_i_resp = 1'b0; e_d_resp = 1'b0;
      if (m_owner == 1) begin
         x_rd = 1'b1; x_addr = i_addr; e_i_resp = l2_resp;
      end else if (m_owner == 2) begin
         x_wr = d_write; x_rd = d_read && !d_write;
         x_addr = d_addr; x_wdata = d_wdata; e_d_resp = l2_resp;
      end
`ifdef L2_ARB_PERF_EN
      x_ig = 16'(m_ig); x_dg = 16'(m_dg); x_iw = 16'(m_iw);
`else
      x_ig = 16'd0; x_dg = 16'd0; x_iw = 16'd0;
`endif
      chk("l2_read",  l2_read,  x_rd);
      chk("l2_write", l2_write, x_wr);
      chk("l2_addr",  l2_addr,  x_addr);
      chk("l2_wdata", l2_wdata, x_wdata);
      chk("i_resp",   i_resp,   e_i_resp);
      chk("d_resp",   d_resp,   e_d_resp);
      chk("i_rdata",  i_rdata,  l2_rdata);
      chk("d_rdata",  d_rdata,  l2_rdata);
      chk("perf_i_grants", perf_i_grants, x_ig);
      chk("perf_d_grants", perf_d_grants, x_dg);
      chk("perf_i_wait",   perf_i_wait,   x_iw);
   endtask

   // Advance the model by the inputs present this cycle, then cross the edge.
   task automatic adv();
      if (reset) begin
         m_owner = 0; m_streak = 0; m_ig = 0; m_dg = 0; m_iw = 0;
      end else begin
         if (i_read && m_owner != 1 && m_iw < 65535) m_iw++;
         if (m_owner == 0) begin
            if ((d_read || d_write) && !(i_read && m_streak == MAXS)) begin
               m_owner = 2;
               if (m_dg < 65535) m_dg++;
               m_streak = i_read ? ((m_streak + 1 > MAXS) ? MAXS : m_streak + 1) : 0;
            end else if (i_read) begin
               m_owner = 1;
               if (m_ig < 65535) m_ig++;
               m_streak = 0;
            end
         end else if (l2_resp) begin
            m_owner = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      samp();
      adv();
   endtask

   initial begin
      logic [ADDR_W-1:0] exp_a;
      total = 0; bad = 0;
      e_i_resp = 1'b0; e_d_resp = 1'b0;
      reset = 1'b1; i_read = 1'b1; i_addr = 16'h0100;
      d_read = 1'b0; d_write = 1'b0; d_addr = 16'h0000; d_wdata = '0;
      l2_rdata = '0; l2_resp = 1'b0;
      // First edge applies reset; state is undefined before it.
      @(posedge clk); #1;
      m_owner = 0; m_streak = 0; m_ig = 0; m_dg = 0; m_iw = 0;

      // Reset held with i_read high; I served one cycle after release.
      samp(); chk("rst_l2_read", l2_read, 1'b0); chk("rst_i_resp", i_resp, 1'b0); adv();
      reset = 1'b0;
      samp(); chk("rel_idle_l2_read", l2_read, 1'b0); adv();
      samp(); chk("serve_i_l2_read", l2_read, 1'b1); chk("serve_i_addr", l2_addr, 16'h0100); adv();
      l2_resp = 1'b1; l2_rdata = {16{8'hA5}};
      samp(); chk("i_resp_pulse", i_resp, 1'b1); chk("i_rdata_a5", i_rdata, {16{8'hA5}}); adv();
      l2_resp = 1'b0; i_read = 1'b0;
      samp(); chk("i_resp_one_cycle", i_resp, 1'b0); adv();

      // Simultaneous requests: D first, I after one IDLE cycle.
      i_read = 1'b1; i_addr = 16'h1000; d_read = 1'b1; d_addr = 16'h0040;
      tick();
      samp(); chk("both_d_first", l2_addr, 16'h0040); adv();
      l2_resp = 1'b1;
      samp(); chk("both_d_resp", d_resp, 1'b1); chk("both_no_i_resp", i_resp, 1'b0); adv();
      l2_resp = 1'b0; d_read = 1'b0;
      samp(); chk("both_turnaround", l2_read, 1'b0); adv();
      samp(); chk("both_i_second", l2_addr, 16'h1000); chk("both_i_read", l2_read, 1'b1); adv();
      l2_resp = 1'b1; tick(); l2_resp = 1'b0;

      // Streak guard: with I pending, 4 D grants, then I, then D again.
      d_read = 1'b1;
      for (int k = 0; k < 6; k++) begin
         exp_a = (k == 4) ? 16'h1000 : 16'h0040;
         l2_resp = 1'b0;
         tick();
         l2_resp = 1'b1;
         samp(); chk($sformatf("streak_grant%0d", k), l2_addr, exp_a); adv();
      end
      l2_resp = 1'b0; i_read = 1'b0; d_read = 1'b0;
      tick();

      // Writeback, then read+write together issues a write only.
      d_write = 1'b1; d_wdata = 128'hDEAD_BEEF; d_addr = 16'h2220;
      tick();
      samp();
      chk("wb_l2_write", l2_write, 1'b1); chk("wb_l2_read", l2_read, 1'b0);
      chk("wb_l2_addr", l2_addr, 16'h2220); chk("wb_l2_wdata", l2_wdata, 128'hDEAD_BEEF);
      adv();
      l2_resp = 1'b1; samp(); chk("wb_d_resp", d_resp, 1'b1); adv();
      l2_resp = 1'b0; d_read = 1'b1;
      tick();
      samp(); chk("rw_write_only", l2_write, 1'b1); chk("rw_no_read", l2_read, 1'b0); adv();
      l2_resp = 1'b1; tick();
      l2_resp = 1'b0; d_read = 1'b0; d_write = 1'b0;
      tick();

      // Spurious l2_resp in IDLE is ignored.
      l2_resp = 1'b1;
      samp(); chk("spur_i_resp", i_resp, 1'b0); chk("spur_d_resp", d_resp, 1'b0); adv();
      l2_resp = 1'b0;
      samp(); chk("spur_still_idle", l2_read, 1'b0); adv();

      // Reset while serving D drops the port and ignores a late resp.
      d_write = 1'b1; d_addr = 16'h3330;
      tick();
      reset = 1'b1;
      samp(); chk("rst_sd_l2_write", l2_write, 1'b1); adv();
      reset = 1'b0; d_write = 1'b0; l2_resp = 1'b1;
      samp(); chk("rst_sd_dropped", l2_write, 1'b0); chk("rst_sd_late_resp", d_resp, 1'b0); adv();
      l2_resp = 1'b0;
      tick();

      // Perf counters: 3 I grants and 5 D grants after a reset.
      reset = 1'b1; tick(); reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         i_read = 1'b1; tick();
         l2_resp = 1'b1; tick();
         l2_resp = 1'b0; i_read = 1'b0;
      end
      for (int k = 0; k < 5; k++) begin
         d_read = 1'b1; tick();
         l2_resp = 1'b1; tick();
         l2_resp = 1'b0; d_read = 1'b0;
      end
      samp();
`ifdef L2_ARB_PERF_EN
      chk("perf3_i_grants", perf_i_grants, 16'd3);
      chk("perf5_d_grants", perf_d_grants, 16'd5);
      chk("perf3_i_wait",   perf_i_wait,   16'd3);
`else
      chk("perf_off_i_grants", perf_i_grants, 16'd0);
      chk("perf_off_d_grants", perf_d_grants, 16'd0);
      chk("perf_off_i_wait",   perf_i_wait,   16'd0);
`endif
      adv();

      // Randomized interleavings against the model.
      for (int c = 0; c < 4000; c++) begin
         reset = ($urandom_range(0, 99) == 0);
         if (i_read) begin
            if (e_i_resp) begin
               if ($urandom_range(0, 9) < 6) i_read = 1'b0;
               else i_addr = 16'($urandom);
            end
         end else if ($urandom_range(0, 3) == 0) begin
            i_read = 1'b1; i_addr = 16'($urandom);
         end
         if (d_read || d_write) begin
            if (e_d_resp && $urandom_range(0, 9) < 6) begin
               d_read = 1'b0; d_write = 1'b0;
            end
         end else if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 9))
               0, 1, 2, 3, 4: begin d_read = 1'b1; d_write = 1'b0; end
               5, 6, 7, 8:    begin d_read = 1'b0; d_write = 1'b1; end
               default:       begin d_read = 1'b1; d_write = 1'b1; end
            endcase
            d_addr  = 16'($urandom);
            d_wdata = {$urandom, $urandom, $urandom, $urandom};
         end
         if (reset) l2_resp = 1'b0;
         else if (m_owner != 0) l2_resp = ($urandom_range(0, 2) == 0);
         else l2_resp = ($urandom_range(0, 19) == 0);
         l2_rdata = {$urandom, $urandom, $urandom, $urandom};
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
